reg_bank_sb: RTL and testbench
==============================

Name: reg_bank_sb

Overview:
- Clocked, parametrised successor to the 16x32 decoder/mux register bank.
- Provides a 2^ADDR_W x DATA_W register file with one write port (write enable) and two asynchronous read ports.
- Optional same-cycle write-to-read bypass and an optional hardwired zero register.
- Adds a per-register busy scoreboard so the issue stage can detect pending writebacks (RAW hazards) and stall.

Parameters:
- DATA_W, 32, data width of every register and of the data ports.
- ADDR_W, 4, address width; register count NREGS = 2**ADDR_W.
- ZERO_REG, 0, if 1 then register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, if 1 then a same-cycle write is forwarded to a matching read port.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write (writeback) address.
- wdata  input  DATA_W  write data.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  DATA_W  read port 1 data.
- rdata2  output  DATA_W  read port 2 data.
- rsv_en  input  1  reserve request: mark rsv_addr busy (instruction issued that will write rsv_addr).
- rsv_addr  input  ADDR_W  register to reserve.
- busy1  output  1  raddr1 has a pending writeback.
- busy2  output  1  raddr2 has a pending writeback.
- busy_any  output  1  OR of all busy bits.

Behaviour:
- Fixed decision: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - All registers become 0 and all busy bits become 0; the write and reserve inputs are ignored that cycle.
  - After reset, rdata1/rdata2 read 0 for every address (unless bypassed); busy1, busy2 and busy_any read 0.
  - Reset has priority over every other event, including a write or reserve in the same cycle.
- Write:
  - On a rising edge with we=1 and rst=0, reg[waddr] <= wdata.
  - Write latency: visible on the registered path the cycle after the edge.
  - we=0 leaves every register unchanged.
- Read (combinational, zero latency):
  - rdataN = reg[raddrN].
  - If BYPASS=1 and we=1 and waddr==raddrN, then rdataN = wdata in the same cycle.
  - If ZERO_REG=1 and raddrN==0, rdataN = 0 regardless of bypass.
  - Both ports may read the same address simultaneously and return identical data.
- Scoreboard, per register, applied on a rising edge with rst=0:
  - we=1 clears busy[waddr].
  - rsv_en=1 sets busy[rsv_addr].
  - Same address written and reserved in the same cycle: set wins (a new producer supersedes the completing one), so busy stays 1.
  - Different addresses: both actions apply independently.
  - Reserving an already-busy register: stays 1, no error.
  - Writing a non-busy register: legal; data is written and busy stays 0.
  - ZERO_REG=1: busy[0] is held at 0; writes to register 0 are discarded.
- Busy outputs (combinational):
  - busyN = busy[raddrN], except busyN = 0 when BYPASS=1, we=1 and waddr==raddrN. The forwarded wdata satisfies the reader even if rsv_en targets the same address that cycle.
  - busy_any = OR of the stored busy bits only; it does not include bypass masking.
- Width rules:
  - No arithmetic is performed.
  - Addresses are always in range by construction (NREGS = 2**ADDR_W), so no out-of-range handling is needed.
- Reset mid-operation: any pending reservations are dropped; the scoreboard restarts empty.

Test Plan:
- Reset then read all 16 addresses on both ports -> all rdata = 0x00000000; busy1 = busy2 = busy_any = 0.
- Write 0xDEADBEEF to r5, then 0x12345678 to r9, then read raddr1=5, raddr2=9 -> rdata1 = 0xDEADBEEF, rdata2 = 0x12345678.
- Bypass: r3 holds 0x11111111; in one cycle set we=1, waddr=3, wdata=0xA5A5A5A5, raddr1=3 -> rdata1 = 0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> rdata1 = 0x11111111, then 0xA5A5A5A5 the next cycle.
- Scoreboard: rsv_en with rsv_addr=7 -> next cycle busy1 = 1 (raddr1=7) and busy_any = 1. Then write r7 with 0xCAFE0001 -> busy1 = 0 during that write cycle (bypass) and after the edge; busy_any = 0.
- Simultaneous events: r4 busy; in one cycle we=1, waddr=4 and rsv_en=1, rsv_addr=4 -> r4 updated and busy[4] stays 1. In another cycle, write r4 while reserving r6 -> busy[4] = 0, busy[6] = 1.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0 -> rdata(0) = 0 and busy = 0 for r0. Then assert rst together with we=1 to r2 and rsv_en to r2 -> r2 = 0 and all busy bits 0 next cycle.

Source files
------------

// File: rtl/reg_bank_sb.sv
// Register file with one write port, two combinational read ports and a busy scoreboard for RAW hazard detection.
// Writes land one edge after we; reads and busy flags are zero-latency, with optional same-cycle write forwarding.
module reg_bank_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              busy_any
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [NREGS-1:0]  wr_dec;
  logic [NREGS-1:0]  rsv_dec;
  logic              fwd1;
  logic              fwd2;

  // One-hot decode of write and reserve; register 0 is masked out when hardwired to zero.
  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_dec[i]  = we     && (waddr    == ADDR_W'(i));
      rsv_dec[i] = rsv_en && (rsv_addr == ADDR_W'(i));
    end
    if (ZERO_REG) begin
      wr_dec[0]  = 1'b0;
      rsv_dec[0] = 1'b0;
    end
  end

  // Set after clear: a newly issued producer supersedes the one completing this cycle.
  always_comb begin
    busy_next = (busy & ~wr_dec) | rsv_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_dec[i]) begin
          regs[i] <= wdata;
        end
      end
      busy <= busy_next;
    end
  end

  always_comb begin
    fwd1 = BYPASS && we && (waddr == raddr1);
    fwd2 = BYPASS && we && (waddr == raddr2);
  end

  // Read port 1: forwarded data also clears the hazard seen by this reader.
  always_comb begin
    rdata1 = regs[raddr1];
    busy1  = busy[raddr1];
    if (fwd1) begin
      rdata1 = wdata;
      busy1  = 1'b0;
    end
    if (ZERO_REG && (raddr1 == '0)) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    busy2  = busy[raddr2];
    if (fwd2) begin
      rdata2 = wdata;
      busy2  = 1'b0;
    end
    if (ZERO_REG && (raddr2 == '0)) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
  end

  // Reports stored reservations only; forwarding does not mask this flag.
  always_comb begin
    busy_any = |busy;
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: three configurations (default, no bypass, zero register) driven in parallel
// and compared against an array-based reference model.
module tb_reg_bank_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  raddr1 = '0;
  logic [3:0]  raddr2 = '0;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_addr = '0;

  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  logic        b1 [3];
  logic        b2 [3];
  logic        ba [3];

  int nchk = 0;
  int nerr = 0;

  logic [31:0] m_mem [3][16];
  bit          m_bsy [3][16];

  always #5 clk = ~clk;

  reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(b1[0]), .busy2(b2[0]), .busy_any(ba[0])
  );

  reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(b1[1]), .busy2(b2[1]), .busy_any(ba[1])
  );

  reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_zr (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(b1[2]), .busy2(b2[2]), .busy_any(ba[2])
  );

  function automatic bit zr_of(int c);
    return c == 2;
  endfunction

  function automatic bit bp_of(int c);
    return c != 1;
  endfunction

  function automatic logic [31:0] exp_rd(int c, logic [3:0] a);
    if (zr_of(c) && a == 4'd0) return 32'h0;
    if (bp_of(c) && we && waddr == a) return wdata;
    return m_mem[c][a];
  endfunction

  function automatic bit exp_busy(int c, logic [3:0] a);
    if (zr_of(c) && a == 4'd0) return 1'b0;
    if (bp_of(c) && we && waddr == a) return 1'b0;
    return m_bsy[c][a];
  endfunction

  function automatic bit exp_any(int c);
    bit r = 1'b0;
    for (int i = 0; i < 16; i++) r = r | m_bsy[c][i];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          m_mem[c][i] = 32'h0;
          m_bsy[c][i] = 1'b0;
        end
      end else begin
        if (we && !(zr_of(c) && waddr == 4'd0)) m_mem[c][waddr] = wdata;
        if (we) m_bsy[c][waddr] = 1'b0;
        if (rsv_en) m_bsy[c][rsv_addr] = 1'b1;
        if (zr_of(c)) m_bsy[c][0] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    we = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 32'h5555AAAA; rsv_en = 1'b1; rsv_addr = 4'd2;
    cycle();
    idle();
    for (int a = 0; a < 16; a++) begin
      raddr1 = 4'(a);
      raddr2 = 4'(15 - a);
      #2;
      for (int c = 0; c < 3; c++) begin
        nchk++;
        if (rd1[c] !== 32'h0) begin nerr++; $display("FAIL reset_rd1 cfg%0d addr%0d: got %h want 00000000", c, a, rd1[c]); end
        nchk++;
        if (rd2[c] !== 32'h0) begin nerr++; $display("FAIL reset_rd2 cfg%0d addr%0d: got %h want 00000000", c, 15 - a, rd2[c]); end
        nchk++;
        if (b1[c] !== 1'b0 || b2[c] !== 1'b0) begin nerr++; $display("FAIL reset_busy cfg%0d addr%0d: got %b%b want 00", c, a, b1[c], b2[c]); end
        nchk++;
        if (ba[c] !== 1'b0) begin nerr++; $display("FAIL reset_busy_any cfg%0d: got %b want 0", c, ba[c]); end
      end
      cycle();
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF;
    cycle();
    waddr = 4'd9; wdata = 32'h12345678;
    cycle();
    idle();
    raddr1 = 4'd5; raddr2 = 4'd9;
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (rd1[c] !== 32'hDEADBEEF) begin nerr++; $display("FAIL wr_rd1 cfg%0d: got %h want deadbeef", c, rd1[c]); end
      nchk++;
      if (rd2[c] !== 32'h12345678) begin nerr++; $display("FAIL wr_rd2 cfg%0d: got %h want 12345678", c, rd2[c]); end
    end
    cycle();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 4'd3; wdata = 32'h11111111;
    cycle();
    wdata = 32'hA5A5A5A5; raddr1 = 4'd3;
    #2;
    nchk++;
    if (rd1[0] !== 32'hA5A5A5A5) begin nerr++; $display("FAIL bypass_fwd cfg0: got %h want a5a5a5a5", rd1[0]); end
    nchk++;
    if (rd1[2] !== 32'hA5A5A5A5) begin nerr++; $display("FAIL bypass_fwd cfg2: got %h want a5a5a5a5", rd1[2]); end
    nchk++;
    if (rd1[1] !== 32'h11111111) begin nerr++; $display("FAIL nobypass_old: got %h want 11111111", rd1[1]); end
    cycle();
    idle();
    #2;
    nchk++;
    if (rd1[1] !== 32'hA5A5A5A5) begin nerr++; $display("FAIL nobypass_new: got %h want a5a5a5a5", rd1[1]); end
    cycle();
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    cycle();
    idle();
    raddr1 = 4'd7;
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (b1[c] !== 1'b1 || ba[c] !== 1'b1) begin nerr++; $display("FAIL sb_reserved cfg%0d: busy1=%b any=%b want 1 1", c, b1[c], ba[c]); end
    end
    cycle();
    we = 1'b1; waddr = 4'd7; wdata = 32'hCAFE0001;
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (b1[c] !== !bp_of(c)) begin nerr++; $display("FAIL sb_wb_cycle cfg%0d: busy1=%b want %b", c, b1[c], !bp_of(c)); end
      nchk++;
      if (ba[c] !== 1'b1) begin nerr++; $display("FAIL sb_wb_any cfg%0d: got %b want 1", c, ba[c]); end
    end
    cycle();
    idle();
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (b1[c] !== 1'b0 || ba[c] !== 1'b0) begin nerr++; $display("FAIL sb_cleared cfg%0d: busy1=%b any=%b want 0 0", c, b1[c], ba[c]); end
      nchk++;
      if (rd1[c] !== 32'hCAFE0001) begin nerr++; $display("FAIL sb_data cfg%0d: got %h want cafe0001", c, rd1[c]); end
    end
    cycle();
  endtask

  task automatic test_simultaneous();
    rsv_en = 1'b1; rsv_addr = 4'd4;
    cycle();
    we = 1'b1; waddr = 4'd4; wdata = 32'h44440001; raddr1 = 4'd4;
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (b1[c] !== !bp_of(c)) begin nerr++; $display("FAIL simul_fwd_busy cfg%0d: got %b want %b", c, b1[c], !bp_of(c)); end
    end
    cycle();
    idle();
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (b1[c] !== 1'b1) begin nerr++; $display("FAIL simul_set_wins cfg%0d: busy1=%b want 1", c, b1[c]); end
      nchk++;
      if (rd1[c] !== 32'h44440001) begin nerr++; $display("FAIL simul_data cfg%0d: got %h want 44440001", c, rd1[c]); end
    end
    cycle();
    we = 1'b1; waddr = 4'd4; wdata = 32'h44440002; rsv_en = 1'b1; rsv_addr = 4'd6;
    cycle();
    idle();
    raddr1 = 4'd4; raddr2 = 4'd6;
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (b1[c] !== 1'b0 || b2[c] !== 1'b1) begin nerr++; $display("FAIL simul_indep cfg%0d: busy4=%b busy6=%b want 0 1", c, b1[c], b2[c]); end
      nchk++;
      if (ba[c] !== 1'b1) begin nerr++; $display("FAIL simul_any cfg%0d: got %b want 1", c, ba[c]); end
    end
    cycle();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 4'd0;
    cycle();
    idle();
    raddr1 = 4'd0; raddr2 = 4'd0;
    #2;
    nchk++;
    if (rd1[2] !== 32'h0 || rd2[2] !== 32'h0) begin nerr++; $display("FAIL zero_rd cfg2: got %h %h want 0 0", rd1[2], rd2[2]); end
    nchk++;
    if (b1[2] !== 1'b0) begin nerr++; $display("FAIL zero_busy cfg2: got %b want 0", b1[2]); end
    nchk++;
    if (rd1[0] !== 32'hFFFFFFFF || b1[0] !== 1'b1) begin nerr++; $display("FAIL r0_normal cfg0: got %h busy=%b want ffffffff 1", rd1[0], b1[0]); end
    cycle();
    rst = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 32'h22222222; rsv_en = 1'b1; rsv_addr = 4'd2;
    cycle();
    idle();
    raddr1 = 4'd2;
    #2;
    for (int c = 0; c < 3; c++) begin
      nchk++;
      if (rd1[c] !== 32'h0) begin nerr++; $display("FAIL rst_prio_data cfg%0d: got %h want 00000000", c, rd1[c]); end
      nchk++;
      if (b1[c] !== 1'b0 || ba[c] !== 1'b0) begin nerr++; $display("FAIL rst_prio_busy cfg%0d: busy1=%b any=%b want 0 0", c, b1[c], ba[c]); end
    end
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      we       = $urandom_range(0, 1);
      waddr    = 4'($urandom_range(0, 15));
      wdata    = $urandom;
      rsv_en   = $urandom_range(0, 1);
      rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 4'($urandom_range(0, 15));
      #2;
      for (int c = 0; c < 3; c++) begin
        nchk++;
        if (rd1[c] !== exp_rd(c, raddr1)) begin nerr++; $display("FAIL rand_rd1 it%0d cfg%0d a%0d: got %h want %h", n, c, raddr1, rd1[c], exp_rd(c, raddr1)); end
        nchk++;
        if (rd2[c] !== exp_rd(c, raddr2)) begin nerr++; $display("FAIL rand_rd2 it%0d cfg%0d a%0d: got %h want %h", n, c, raddr2, rd2[c], exp_rd(c, raddr2)); end
        nchk++;
        if (b1[c] !== exp_busy(c, raddr1)) begin nerr++; $display("FAIL rand_busy1 it%0d cfg%0d a%0d: got %b want %b", n, c, raddr1, b1[c], exp_busy(c, raddr1)); end
        nchk++;
        if (b2[c] !== exp_busy(c, raddr2)) begin nerr++; $display("FAIL rand_busy2 it%0d cfg%0d a%0d: got %b want %b", n, c, raddr2, b2[c], exp_busy(c, raddr2)); end
        nchk++;
        if (ba[c] !== exp_any(c)) begin nerr++; $display("FAIL rand_busy_any it%0d cfg%0d: got %b want %b", n, c, ba[c], exp_any(c)); end
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_zero_reg();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
